// File: rtl/stage_post_rotation.sv
`default_nettype none
// ============================================================================
// Module   : stage_post_rotation
// Brief    : Receive end of the pre-rotation -> CORDIC path. Accepts one
//            primitive context, then collects the rotated vertices that the
//            CORDIC core returns serially. Results are tagged by index and may
//            arrive in any order. Each vertex is rounded, translated back by
//            the reference point and saturated. The assembled primitive is
//            then offered downstream through a valid/ready handshake.
// Config   : POSTROT_TIMEOUT_EN - when defined, a stalled COLLECT aborts after
//            TIMEOUT idle cycles. The primitive is then emitted as a bubble.
// Revision : 1.0 - initial release
// ============================================================================
module stage_post_rotation #(
  parameter int CW      = 19,
  parameter int FRAC    = 8,
  parameter int VW      = 11,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_bubble,
  input  logic            in_enable_cordic,
  input  logic [8:0]      in_color,
  input  logic [9:0]      in_pixel_x,
  input  logic [9:0]      in_pixel_y,
  input  logic [8:0]      in_ref_point_x,
  input  logic [8:0]      in_ref_point_y,
  input  logic            in_form,
  input  logic            cord_valid,
  input  logic [1:0]      cord_idx,
  input  logic [CW-1:0]   cord_x,
  input  logic [CW-1:0]   cord_y,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_bubble,
  output logic [8:0]      out_color,
  output logic [9:0]      out_pixel_x,
  output logic [9:0]      out_pixel_y,
  output logic            out_form,
  output logic [4*VW-1:0] out_vx,
  output logic [4*VW-1:0] out_vy,
  output logic [2:0]      err_flags
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_EMIT    = 2'd2
  } state_t;

  // Rounding constant and saturation bounds, all at the CW+1 working width
  localparam logic signed [CW:0] c_half = (CW+1)'(2**(FRAC-1));
  localparam logic signed [CW:0] c_vmax = (CW+1)'(2**(VW-1) - 1);
  localparam logic signed [CW:0] c_vmin = ~c_vmax;

  // Reject configurations where the arithmetic below is meaningless
  if (FRAC < 1 || FRAC >= CW || VW < 2 || TIMEOUT < 1) begin : g_param_check
    $error("stage_post_rotation: illegal parameter combination");
  end

  // Round-half-up to integer, add the unsigned reference, clamp to VW bits.
  // Widening to CW+1 first keeps the rounding add from wrapping at the
  // positive end of the CORDIC range.
  function automatic logic [VW-1:0] f_round_sat(input logic [CW-1:0] cord,
                                                input logic [8:0]    ref_pt);
    logic signed [CW:0] w_ext;
    logic signed [CW:0] w_rnd;
    logic signed [CW:0] w_sum;
    w_ext = $signed({cord[CW-1], cord});
    w_rnd = (w_ext + c_half) >>> FRAC;
    w_sum = w_rnd + $signed({{(CW-8){1'b0}}, ref_pt});
    if (w_sum > c_vmax) begin
      return c_vmax[VW-1:0];
    end else if (w_sum < c_vmin) begin
      return c_vmin[VW-1:0];
    end else begin
      return w_sum[VW-1:0];
    end
  endfunction

  state_t          r_state;
  state_t          w_state_next;
  logic            r_bubble;
  logic [8:0]      r_color;
  logic [9:0]      r_pixel_x;
  logic [9:0]      r_pixel_y;
  logic [8:0]      r_ref_x;
  logic [8:0]      r_ref_y;
  logic            r_form;
  logic [4*VW-1:0] r_vx;
  logic [4*VW-1:0] r_vy;
  logic [3:0]      r_mask;
  logic [2:0]      r_err;

  logic [VW-1:0]   w_vx_new;
  logic [VW-1:0]   w_vy_new;
  logic            w_idx_ok;
  logic [3:0]      w_mask_upd;
  logic            w_complete;
  logic            w_tmo_hit;

  // Vertex conversion and mask bookkeeping for the result on the bus
  always_comb begin
    w_vx_new   = f_round_sat(cord_x, r_ref_x);
    w_vy_new   = f_round_sat(cord_y, r_ref_y);
    w_idx_ok   = !((cord_idx == 2'd3) && !r_form);
    w_mask_upd = r_mask;
    if (w_idx_ok) begin
      w_mask_upd[cord_idx] = 1'b1;
    end
    w_complete = r_form ? (&w_mask_upd) : (&w_mask_upd[2:0]);
  end

`ifdef POSTROT_TIMEOUT_EN
  localparam int              c_tw       = $clog2(TIMEOUT + 1);
  localparam logic [c_tw-1:0] c_tmo_last = c_tw'(TIMEOUT - 1);

  logic [c_tw-1:0] r_tmo_cnt;

  // Idle-cycle counter, restarted on entry to COLLECT and by every result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tmo_cnt <= '0;
    end else if ((r_state != S_COLLECT) || cord_valid) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + c_tw'(1);
    end
  end

  // A result on the expiry cycle takes priority over the timeout
  assign w_tmo_hit = (r_state == S_COLLECT) && !cord_valid && (r_tmo_cnt == c_tmo_last);
`else
  assign w_tmo_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state: one context per visit to IDLE, no back-to-back accept
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          if (in_bubble || !in_enable_cordic) begin
            w_state_next = S_EMIT;
          end else begin
            w_state_next = S_COLLECT;
          end
        end
      end
      S_COLLECT: begin
        if ((cord_valid && w_idx_ok && w_complete) || w_tmo_hit) begin
          w_state_next = S_EMIT;
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Context capture, vertex storage and sticky error flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bubble  <= 1'b0;
      r_color   <= '0;
      r_pixel_x <= '0;
      r_pixel_y <= '0;
      r_ref_x   <= '0;
      r_ref_y   <= '0;
      r_form    <= 1'b0;
      r_vx      <= '0;
      r_vy      <= '0;
      r_mask    <= '0;
      r_err     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cord_valid) begin
            r_err[0] <= 1'b1;
          end
          if (in_valid) begin
            r_bubble  <= in_bubble;
            r_color   <= in_color;
            r_pixel_x <= in_pixel_x;
            r_pixel_y <= in_pixel_y;
            r_ref_x   <= in_ref_point_x;
            r_ref_y   <= in_ref_point_y;
            r_form    <= in_form;
            r_vx      <= '0;
            r_vy      <= '0;
            r_mask    <= '0;
          end
        end
        S_COLLECT: begin
          if (cord_valid) begin
            if (w_idx_ok) begin
              r_vx[cord_idx*VW +: VW] <= w_vx_new;
              r_vy[cord_idx*VW +: VW] <= w_vy_new;
              r_mask                  <= w_mask_upd;
            end else begin
              r_err[1] <= 1'b1;
            end
          end else if (w_tmo_hit) begin
            r_bubble <= 1'b1;
            r_err[2] <= 1'b1;
          end
        end
        S_EMIT: begin
          if (cord_valid) begin
            r_err[0] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = (r_state == S_EMIT);
  assign out_bubble  = r_bubble;
  assign out_color   = r_color;
  assign out_pixel_x = r_pixel_x;
  assign out_pixel_y = r_pixel_y;
  assign out_form    = r_form;
  assign out_vx      = r_vx;
  assign out_vy      = r_vy;
  assign err_flags   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_stage_post_rotation.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_stage_post_rotation
// Brief    : Self-checking bench for stage_post_rotation. A transaction-level
//            model predicts each emitted primitive and the sticky error flags.
//            Directed cases cover the key scenarios; a randomised run follows.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stage_post_rotation;
  localparam int CW      = 19;
  localparam int FRAC    = 8;
  localparam int VW      = 11;
  localparam int TIMEOUT = 64;
  localparam int VMAX    = 2**(VW-1) - 1;
  localparam int VMIN    = -(2**(VW-1));

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic            in_bubble;
  logic            in_enable_cordic;
  logic [8:0]      in_color;
  logic [9:0]      in_pixel_x;
  logic [9:0]      in_pixel_y;
  logic [8:0]      in_ref_point_x;
  logic [8:0]      in_ref_point_y;
  logic            in_form;
  logic            cord_valid;
  logic [1:0]      cord_idx;
  logic [CW-1:0]   cord_x;
  logic [CW-1:0]   cord_y;
  logic            out_valid;
  logic            out_ready;
  logic            out_bubble;
  logic [8:0]      out_color;
  logic [9:0]      out_pixel_x;
  logic [9:0]      out_pixel_y;
  logic            out_form;
  logic [4*VW-1:0] out_vx;
  logic [4*VW-1:0] out_vy;
  logic [2:0]      err_flags;

  stage_post_rotation #(.CW(CW), .FRAC(FRAC), .VW(VW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_bubble(in_bubble),
    .in_enable_cordic(in_enable_cordic), .in_color(in_color),
    .in_pixel_x(in_pixel_x), .in_pixel_y(in_pixel_y),
    .in_ref_point_x(in_ref_point_x), .in_ref_point_y(in_ref_point_y),
    .in_form(in_form), .cord_valid(cord_valid), .cord_idx(cord_idx),
    .cord_x(cord_x), .cord_y(cord_y), .out_valid(out_valid),
    .out_ready(out_ready), .out_bubble(out_bubble), .out_color(out_color),
    .out_pixel_x(out_pixel_x), .out_pixel_y(out_pixel_y), .out_form(out_form),
    .out_vx(out_vx), .out_vy(out_vy), .err_flags(err_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            bubble;
    logic            form;
    logic [8:0]      color;
    logic [9:0]      px;
    logic [9:0]      py;
    logic [4*VW-1:0] vx;
    logic [4*VW-1:0] vy;
  } prim_t;

  prim_t      exp_q[$];
  prim_t      cur;
  int         cur_rx = 0;
  int         cur_ry = 0;
  logic [3:0] mask = '0;
  bit         in_collect = 0;
  logic [2:0] exp_err = '0;
  bit         rand_ready = 0;
  int         total = 0;
  int         bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference vertex: round half up, shift back to integer, add ref, clamp
  function automatic int rsat(input int c, input int r);
    int v;
    v = ((c + 2**(FRAC-1)) >>> FRAC) + r;
    if (v > VMAX) v = VMAX;
    if (v < VMIN) v = VMIN;
    return v;
  endfunction

  function automatic int rnd_cord();
    logic [CW-1:0] r;
    r = CW'($urandom);
    return int'($signed(r));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_ctx(input bit bub, input bit en, input bit form, input int rx, input int ry);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready) chk("ctx_accept_wait", in_ready, 1);
    cur.bubble = bub;
    cur.form   = form;
    cur.color  = 9'($urandom);
    cur.px     = 10'($urandom);
    cur.py     = 10'($urandom);
    cur.vx     = '0;
    cur.vy     = '0;
    cur_rx     = rx;
    cur_ry     = ry;
    mask       = '0;
    in_valid         = 1'b1;
    in_bubble        = bub;
    in_enable_cordic = en;
    in_form          = form;
    in_color         = cur.color;
    in_pixel_x       = cur.px;
    in_pixel_y       = cur.py;
    in_ref_point_x   = 9'(rx);
    in_ref_point_y   = 9'(ry);
    tick();
    in_valid       = 1'b0;
    in_form        = 1'($urandom);
    in_ref_point_x = 9'($urandom);
    in_ref_point_y = 9'($urandom);
    in_color       = 9'($urandom);
    if (bub || !en) begin
      exp_q.push_back(cur);
      chk("ctx_emit_latency", out_valid, 1);
    end else begin
      in_collect = 1;
    end
  endtask

  task automatic send_res(input int idx, input int x, input int y);
    int v;
    cord_valid = 1'b1;
    cord_idx   = 2'(idx);
    cord_x     = CW'(x);
    cord_y     = CW'(y);
    tick();
    cord_valid = 1'b0;
    cord_x     = CW'($urandom);
    cord_y     = CW'($urandom);
    if (!in_collect) begin
      exp_err[0] = 1'b1;
    end else if (idx == 3 && !cur.form) begin
      exp_err[1] = 1'b1;
    end else begin
      v = rsat(x, cur_rx);
      cur.vx[idx*VW +: VW] = v[VW-1:0];
      v = rsat(y, cur_ry);
      cur.vy[idx*VW +: VW] = v[VW-1:0];
      mask[idx] = 1'b1;
      if (cur.form ? (&mask) : (&mask[2:0])) begin
        in_collect = 0;
        exp_q.push_back(cur);
        chk("result_emit_latency", out_valid, 1);
      end
    end
  endtask

  // Per-cycle comparison of the DUT against the model
  always @(negedge clk) begin
    if (reset) begin
      chk("err_flags", err_flags, exp_err);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", out_valid, 0);
        end else begin
          chk("out_bubble", out_bubble, exp_q[0].bubble);
          chk("out_form", out_form, exp_q[0].form);
          chk("out_color", out_color, exp_q[0].color);
          chk("out_pixel_x", out_pixel_x, exp_q[0].px);
          chk("out_pixel_y", out_pixel_y, exp_q[0].py);
          chk("out_vx", out_vx, exp_q[0].vx);
          chk("out_vy", out_vy, exp_q[0].vy);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [8:0]      h_color;
    logic [4*VW-1:0] h_vx;
    int              cyc;
    int              ord[4];
    int              n;
    int              j;
    int              t;
    bit              frm;
    bit              bub;

    reset = 1'b0; in_valid = 1'b0; in_bubble = 1'b0; in_enable_cordic = 1'b0;
    in_color = '0; in_pixel_x = '0; in_pixel_y = '0; in_ref_point_x = '0;
    in_ref_point_y = '0; in_form = 1'b0; cord_valid = 1'b0; cord_idx = '0;
    cord_x = '0; cord_y = '0; out_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err", err_flags, 0);
    chk("rst_vx", out_vx, 0);
    chk("rst_bubble", out_bubble, 0);
    chk("rst_color", out_color, 0);

    // Pin the model on hand-computed values
    chk("model_pin_x", rsat(2688, 100), 111);
    chk("model_pin_y", rsat(-832, 50), 47);
    chk("model_pin_sat", rsat(1000*256, 511), 1023);

    // Quad, out-of-order results, all vertices (111,47)
    send_ctx(0, 1, 1, 100, 50);
    send_res(2, 2688, -832);
    send_res(0, 2688, -832);
    send_res(3, 2688, -832);
    send_res(1, 2688, -832);
    chk("quad_vx", out_vx, {4{11'd111}});
    chk("quad_vy", out_vy, {4{11'd47}});
    tick();
    chk("quad_done_valid", out_valid, 0);
    chk("quad_done_ready", in_ready, 1);

    // Triangle with an illegal idx 3 mid-collection
    send_ctx(0, 1, 0, 200, 300 % 512);
    send_res(0, rnd_cord(), rnd_cord());
    send_res(1, rnd_cord(), rnd_cord());
    send_res(3, rnd_cord(), rnd_cord());
    chk("tri_err1", err_flags[1], 1);
    send_res(2, rnd_cord(), rnd_cord());
    chk("tri_v3_zero", out_vx[3*VW +: VW], 0);
    tick();

    // Bubble held under backpressure
    out_ready = 1'b0;
    send_ctx(1, 1, 0, 7, 9);
    chk("bub_flag", out_bubble, 1);
    chk("bub_vx", out_vx, 0);
    h_color = out_color;
    h_vx    = out_vx;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("hold_valid", out_valid, 1);
      chk("hold_color", out_color, h_color);
      chk("hold_vx", out_vx, h_vx);
    end
    out_ready = 1'b1;
    tick();
    chk("bub_release", out_valid, 0);
    send_ctx(0, 0, 1, 3, 4);
    tick();

    // Saturation at both ends
    send_ctx(0, 1, 0, 511, 0);
    send_res(0, 1000*256, -1024*256);
    send_res(1, rnd_cord(), rnd_cord());
    send_res(2, rnd_cord(), rnd_cord());
    chk("sat_max", out_vx[VW-1:0], 11'h3ff);
    chk("sat_min", out_vy[VW-1:0], 11'h400);
    tick();

    // Orphan result while idle
    send_res(1, 5, 5);
    chk("orphan_err0", err_flags[0], 1);

    // Reset in the middle of a quad
    send_ctx(0, 1, 1, 10, 20);
    send_res(0, rnd_cord(), rnd_cord());
    send_res(1, rnd_cord(), rnd_cord());
    reset = 1'b0;
    in_collect = 0;
    exp_err = '0;
    tick();
    chk("midrst_valid", out_valid, 0);
    chk("midrst_err", err_flags, 0);
    reset = 1'b1;
    tick();
    chk("midrst_in_ready", in_ready, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("midrst_no_valid", out_valid, 0);
    end
    send_ctx(0, 1, 1, 123, 456 % 512);
    for (int k = 0; k < 4; k++) send_res(k, rnd_cord(), rnd_cord());
    tick();

`ifdef POSTROT_TIMEOUT_EN
    // One result, then silence until the abort
    send_ctx(0, 1, 1, 30, 40);
    send_res(2, rnd_cord(), rnd_cord());
    cyc = 0;
    while (!out_valid && cyc < TIMEOUT + 10) begin
      tick();
      cyc++;
    end
    cur.bubble = 1'b1;
    in_collect = 0;
    exp_err[2] = 1'b1;
    exp_q.push_back(cur);
    chk("timeout_cycle", cyc, TIMEOUT);
    chk("timeout_bubble", out_bubble, 1);
    tick();
`else
    // Without the timeout a stalled collection waits indefinitely
    send_ctx(0, 1, 1, 30, 40);
    send_res(2, rnd_cord(), rnd_cord());
    cyc = 0;
    repeat (80) begin
      tick();
      cyc++;
    end
    chk("no_timeout_valid", out_valid, 0);
    chk("no_timeout_err2", err_flags[2], 0);
    send_res(0, rnd_cord(), rnd_cord());
    send_res(3, rnd_cord(), rnd_cord());
    send_res(1, rnd_cord(), rnd_cord());
    tick();
`endif

    // Randomised primitives with random backpressure
    rand_ready = 1;
    for (int p = 0; p < 40; p++) begin
      frm = 1'($urandom);
      n   = frm ? 4 : 3;
      if ($urandom_range(0, 6) == 0) begin
        bub = 1'($urandom);
        send_ctx(bub, bub ? 1'($urandom) : 1'b0, frm,
                 int'($urandom_range(0, 511)), int'($urandom_range(0, 511)));
      end else begin
        send_ctx(0, 1, frm, int'($urandom_range(0, 511)), int'($urandom_range(0, 511)));
        for (int i = 0; i < 4; i++) ord[i] = i;
        for (int i = n - 1; i > 0; i--) begin
          j = int'($urandom_range(0, i));
          t = ord[i];
          ord[i] = ord[j];
          ord[j] = t;
        end
        for (int k = 0; k < n; k++) begin
          if (k > 0 && $urandom_range(0, 4) == 0)
            send_res(ord[$urandom_range(0, k - 1)], rnd_cord(), rnd_cord());
          if (!frm && $urandom_range(0, 5) == 0)
            send_res(3, rnd_cord(), rnd_cord());
          repeat ($urandom_range(0, 2)) tick();
          send_res(ord[k], rnd_cord(), rnd_cord());
        end
        if ($urandom_range(0, 3) == 0)
          send_res(int'($urandom_range(0, 3)), rnd_cord(), rnd_cord());
      end
    end

    rand_ready = 0;
    out_ready  = 1'b1;
    repeat (3) tick();
    chk("queue_drained", exp_q.size(), 0);
    chk("final_valid", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
